// File: rtl/prpg_misr_compactor.sv
// prpg_misr_compactor
//   Sink for a PRPG pattern stream. It compacts a run of WIDTH-bit patterns into
//   a MISR signature, then compares that signature with a golden value and
//   reports done/pass. Vectors declared [0:WIDTH-1] use index 0 as the MSB.
//
//   Optional feature macro: MISR_HD_STATS_EN
//     Adds the HD_W parameter and the hd_total output. hd_total is a saturating
//     sum of the Hamming distances between consecutive accepted patterns.
//     When the macro is undefined, no popcount logic is built.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse; latches cfg_*; honoured only in IDLE or DONE
//   cfg_tap   MISR feedback taps; cfg_tap[WIDTH-1-i] governs bit i (i >= 1)
//   cfg_seed  initial signature
//   cfg_len   number of patterns to compact (0 skips straight to the check)
//   cfg_gold  expected signature
//   pat_valid pattern valid
//   pat_in    pattern
//   pat_ready high only while running
//   sig       current signature
//   pat_cnt   patterns accepted since start
//   busy      running or checking
//   done      result available
//   pass      registered (sig == gold); meaningful while done = 1
//   hd_total  (MISR_HD_STATS_EN) accumulated Hamming distance
module prpg_misr_compactor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
`ifdef MISR_HD_STATS_EN
  , parameter int HD_W = 12
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-2:0] cfg_tap,
  input  logic [0:WIDTH-1] cfg_seed,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [0:WIDTH-1] cfg_gold,
  input  logic             pat_valid,
  input  logic [0:WIDTH-1] pat_in,
  output logic             pat_ready,
  output logic [0:WIDTH-1] sig,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef MISR_HD_STATS_EN
  , output logic [HD_W-1:0] hd_total
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [0:WIDTH-1] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-2:0] tap_q, tap_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [0:WIDTH-1] gold_q, gold_d;
  logic             accept;

  // One MISR step: shift toward the LSB end, the old LSB feeds back into the
  // MSB and into every tapped position, then the pattern is XORed in.
  function automatic logic [0:WIDTH-1] misr_step(input logic [0:WIDTH-1] m,
                                                 input logic [0:WIDTH-1] d,
                                                 input logic [WIDTH-2:0] t);
    logic [0:WIDTH-1] r;
    r[0] = m[WIDTH-1] ^ d[0];
    for (int i = 1; i < WIDTH; i++)
      r[i] = (t[WIDTH-1-i] ? (m[WIDTH-1] ^ m[i-1]) : m[i-1]) ^ d[i];
    return r;
  endfunction

`ifdef MISR_HD_STATS_EN
  logic [0:WIDTH-1] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [HD_W-1:0]  hd_q, hd_d;

  function automatic logic [HD_W:0] popcount(input logic [0:WIDTH-1] v);
    logic [HD_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (HD_W+1)'(v[i]);
    return c;
  endfunction

  // acc is never above its maximum and the increment is at most WIDTH, so
  // one extra bit is enough to detect overflow.
  function automatic logic [HD_W-1:0] sat_add(input logic [HD_W-1:0] acc,
                                              input logic [HD_W:0]   inc);
    logic [HD_W:0] s;
    s = {1'b0, acc} + inc;
    return s[HD_W] ? {HD_W{1'b1}} : s[HD_W-1:0];
  endfunction
`endif

  assign accept = (state_q == S_RUN) && pat_valid;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    tap_d   = tap_q;
    len_d   = len_q;
    gold_d  = gold_q;
`ifdef MISR_HD_STATS_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    hd_d        = hd_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (cfg_len == '0) ? S_CHECK : S_RUN;
          sig_d   = cfg_seed;
          cnt_d   = '0;
          pass_d  = 1'b0;
          tap_d   = cfg_tap;
          len_d   = cfg_len;
          gold_d  = cfg_gold;
`ifdef MISR_HD_STATS_EN
          have_prev_d = 1'b0;
          hd_d        = '0;
`endif
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d = misr_step(sig_q, pat_in, tap_q);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == len_q) state_d = S_CHECK;
`ifdef MISR_HD_STATS_EN
          prev_d      = pat_in;
          have_prev_d = 1'b1;
          if (have_prev_q) hd_d = sat_add(hd_q, popcount(prev_q ^ pat_in));
`endif
        end
      end
      S_CHECK: begin
        pass_d  = (sig_q == gold_q);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they are true registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MISR_HD_STATS_EN
      have_prev_q <= 1'b0;
      hd_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      ready_q <= (state_d == S_RUN);
      busy_q  <= (state_d == S_RUN) || (state_d == S_CHECK);
      done_q  <= (state_d == S_DONE);
`ifdef MISR_HD_STATS_EN
      have_prev_q <= have_prev_d;
      hd_q        <= hd_d;
`endif
    end
  end

  // Latched configuration is only consumed after a start reloads it.
  always_ff @(posedge clk) begin
    tap_q  <= tap_d;
    len_q  <= len_d;
    gold_q <= gold_d;
`ifdef MISR_HD_STATS_EN
    prev_q <= prev_d;
`endif
  end

  assign pat_ready = ready_q;
  assign sig       = sig_q;
  assign pat_cnt   = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
`ifdef MISR_HD_STATS_EN
  assign hd_total  = hd_q;
`endif

endmodule

// File: tb/tb_prpg_misr_compactor.sv
// tb_prpg_misr_compactor
//   Randomized self-checking bench for prpg_misr_compactor. The reference
//   treats the signature as an integer (index 0 = MSB). It applies a Galois
//   right-shift with polynomial {1, taps}, which is equivalent to the
//   bit-level MISR rule. Define MISR_HD_STATS_EN to also check hd_total; the
//   bench then builds the DUT with a small HD_W so that saturation is reachable.
module tb_prpg_misr_compactor;
  localparam int W     = 8;
  localparam int CNT_W = 8;
`ifdef MISR_HD_STATS_EN
  localparam int HD_W  = 6;
  localparam int HDMAX = (1 << HD_W) - 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [W-2:0]     cfg_tap = '0;
  logic [0:W-1]     cfg_seed = '0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [0:W-1]     cfg_gold = '0;
  logic             pat_valid = 1'b0;
  logic [0:W-1]     pat_in = '0;
  logic             pat_ready;
  logic [0:W-1]     sig;
  logic [CNT_W-1:0] pat_cnt;
  logic             busy, done, pass;
`ifdef MISR_HD_STATS_EN
  logic [HD_W-1:0]  hd_total;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_sig;
  logic [W-2:0] m_tap;
  logic [W-1:0] m_prev;
  int           m_cnt;
  int           m_hd;
  bit           m_has_prev;

  always #5 clk = ~clk;

  prpg_misr_compactor #(
    .WIDTH(W), .CNT_W(CNT_W)
`ifdef MISR_HD_STATS_EN
    , .HD_W(HD_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
    .cfg_len(cfg_len), .cfg_gold(cfg_gold), .pat_valid(pat_valid), .pat_in(pat_in),
    .pat_ready(pat_ready), .sig(sig), .pat_cnt(pat_cnt), .busy(busy), .done(done),
    .pass(pass)
`ifdef MISR_HD_STATS_EN
    , .hd_total(hd_total)
`endif
  );

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input logic [W-1:0] d,
                                            input logic [W-2:0] t);
    logic [W-1:0] poly;
    poly = {1'b1, t};
    return (v >> 1) ^ (v[0] ? poly : '0) ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic [W-1:0] d);
`ifdef MISR_HD_STATS_EN
    if (m_has_prev) begin
      m_hd = m_hd + $countones(m_prev ^ d);
      if (m_hd > HDMAX) m_hd = HDMAX;
    end
`endif
    m_prev     = d;
    m_has_prev = 1'b1;
    m_sig      = ref_step(m_sig, d, m_tap);
    m_cnt++;
  endtask

  task automatic do_start(input logic [W-2:0] t, input logic [W-1:0] s,
                          input logic [CNT_W-1:0] l, input logic [W-1:0] g);
    cfg_tap = t; cfg_seed = s; cfg_len = l; cfg_gold = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_tap = t; m_sig = s; m_cnt = 0; m_hd = 0; m_has_prev = 1'b0;
  endtask

  task automatic send_one(input logic [W-1:0] d);
    int n;
    n = 0;
    while (pat_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (pat_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%b want=1", pat_ready);
    end
    pat_valid = 1'b1;
    pat_in = d;
    tick();
    pat_valid = 1'b0;
    model_accept(d);
  endtask

  // Full run with random (mode 0) or alternating (mode 1) pat_valid. A stray
  // start pulse is injected mid-run and must be ignored. Gold is either the
  // predicted signature or a value that differs from it.
  task automatic run_random(input int l, input int mode, input bit match);
    logic [W-1:0] pats[256];
    logic [W-1:0] pred, gold, t8;
    logic [W-2:0] t;
    logic [W-1:0] s;
    bit           v;
    int           budget;
    t8 = W'($urandom);
    t  = t8[W-2:0];
    s  = W'($urandom);
    pred = s;
    for (int i = 0; i < l; i++) begin
      pats[i] = W'($urandom);
      pred = ref_step(pred, pats[i], t);
    end
    gold = match ? pred : (pred ^ W'(1 + $urandom_range(0, 254)));
    do_start(t, s, CNT_W'(l), gold);
    budget = 4 * l + 40;
    for (int cyc = 0; cyc < budget && m_cnt < l; cyc++) begin
      v = (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
      pat_valid = v;
      pat_in = pats[m_cnt];
      if (cyc == 1) begin
        start = 1'b1;
        cfg_seed = ~s;
        cfg_len = '0;
      end
      total++;
      if (pat_ready !== 1'b1) begin
        bad++;
        $display("FAIL run_ready cyc=%0d got=%b want=1", cyc, pat_ready);
      end
      tick();
      start = 1'b0;
      if (v) model_accept(pats[m_cnt]);
      total++;
      if (sig !== m_sig || pat_cnt !== CNT_W'(m_cnt)) begin
        bad++;
        $display("FAIL run_sig cyc=%0d got=%h/%0d want=%h/%0d", cyc, sig, pat_cnt, m_sig, m_cnt);
      end
    end
    pat_valid = 1'b0;
    total++;
    if (m_cnt != l) begin
      bad++;
      $display("FAIL run_timeout got=%0d want=%0d accepts", m_cnt, l);
    end
    total++;
    if ({busy, done, pat_ready} !== 3'b100) begin
      bad++;
      $display("FAIL run_check_state got=%b want=100", {busy, done, pat_ready});
    end
    tick();
    total++;
    if ({busy, done, pass} !== {2'b01, match} || sig !== pred) begin
      bad++;
      $display("FAIL run_done got=%b sig=%h want=%b sig=%h", {busy, done, pass}, sig, {2'b01, match}, pred);
    end
`ifdef MISR_HD_STATS_EN
    total++;
    if (hd_total !== HD_W'(m_hd)) begin
      bad++;
      $display("FAIL run_hd got=%0d want=%0d", hd_total, m_hd);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({pat_ready, busy, done, pass} !== 4'b0 || sig !== '0 || pat_cnt !== '0) begin
      bad++;
      $display("FAIL reset got=%b sig=%h cnt=%0d want=0000 sig=00 cnt=0",
               {pat_ready, busy, done, pass}, sig, pat_cnt);
    end
`ifdef MISR_HD_STATS_EN
    total++;
    if (hd_total !== '0) begin
      bad++;
      $display("FAIL reset_hd got=%0d want=0", hd_total);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_start('0, 8'h00, 8'd1, 8'hA5);
    total++;
    if ({pat_ready, busy, done} !== 3'b110) begin
      bad++;
      $display("FAIL t1_run got=%b want=110", {pat_ready, busy, done});
    end
    send_one(8'hA5);
    total++;
    if (sig !== 8'hA5 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_sig got=%h d=%b b=%b want=a5 d=0 b=1", sig, done, busy);
    end
    tick();
    total++;
    if ({done, pass, busy} !== 3'b110 || pat_cnt !== 8'd1) begin
      bad++;
      $display("FAIL t1_done got=%b cnt=%0d want=110 cnt=1", {done, pass, busy}, pat_cnt);
    end
  endtask

  task automatic test_two_patterns();
    logic [W-1:0] golds[2];
    golds[0] = 8'h41;
    golds[1] = 8'h42;
    for (int k = 0; k < 2; k++) begin
      do_start('0, 8'h00, 8'd2, golds[k]);
      send_one(8'h80);
      total++;
      if (sig !== 8'h80) begin
        bad++;
        $display("FAIL t2_first got=%h want=80", sig);
      end
      send_one(8'h01);
      total++;
      if (sig !== 8'h41) begin
        bad++;
        $display("FAIL t2_final got=%h want=41", sig);
      end
      tick();
      total++;
      if (done !== 1'b1 || pass !== (k == 0)) begin
        bad++;
        $display("FAIL t2_pass gold=%h got=%b%b want=1%b", golds[k], done, pass, k == 0);
      end
    end
    // pat_valid while DONE must be ignored
    pat_valid = 1'b1;
    pat_in = 8'hFF;
    repeat (3) tick();
    pat_valid = 1'b0;
    total++;
    if (sig !== 8'h41 || pat_cnt !== 8'd2 || done !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL done_hold got=%h/%0d/%b%b want=41/2/10", sig, pat_cnt, done, pass);
    end
  endtask

  task automatic test_len_zero();
    bit saw_ready;
    saw_ready = pat_ready;
    do_start('0, 8'h3C, 8'd0, 8'h3C);
    saw_ready |= pat_ready;
    total++;
    if ({busy, done} !== 2'b10 || sig !== 8'h3C) begin
      bad++;
      $display("FAIL t3_check got=%b sig=%h want=10 sig=3c", {busy, done}, sig);
    end
    tick();
    saw_ready |= pat_ready;
    total++;
    if ({busy, done, pass} !== 3'b011 || saw_ready) begin
      bad++;
      $display("FAIL t3_done got=%b ready_seen=%b want=011 ready_seen=0", {busy, done, pass}, saw_ready);
    end
  endtask

  task automatic test_mid_reset();
    do_start(7'h1D, 8'h5A, 8'd4, 8'h00);
    send_one(8'h12);
    send_one(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({pat_ready, busy, done, pass} !== 4'b0 || sig !== '0 || pat_cnt !== '0) begin
      bad++;
      $display("FAIL t5_reset got=%b sig=%h cnt=%0d want=0000 sig=00 cnt=0",
               {pat_ready, busy, done, pass}, sig, pat_cnt);
    end
`ifdef MISR_HD_STATS_EN
    total++;
    if (hd_total !== '0) begin
      bad++;
      $display("FAIL t5_hd got=%0d want=0", hd_total);
    end
`endif
    run_random(4, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++)
      run_random($urandom_range(1, 20), 0, 1'($urandom_range(0, 1)));
    run_random(255, 0, 1'b1);
  endtask

`ifdef MISR_HD_STATS_EN
  task automatic test_hd();
    do_start('0, 8'h00, 8'd3, 8'h00);
    send_one(8'h00);
    send_one(8'hFF);
    send_one(8'h0F);
    total++;
    if (hd_total !== HD_W'(12)) begin
      bad++;
      $display("FAIL t6_hd got=%0d want=12", hd_total);
    end
    tick();
    do_start('0, 8'h00, 8'd12, 8'h00);
    total++;
    if (hd_total !== '0) begin
      bad++;
      $display("FAIL t6_clear got=%0d want=0", hd_total);
    end
    for (int i = 0; i < 12; i++) send_one(i[0] ? 8'hFF : 8'h00);
    total++;
    if (hd_total !== HD_W'(HDMAX) || m_hd != HDMAX) begin
      bad++;
      $display("FAIL hd_sat got=%0d want=%0d", hd_total, HDMAX);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_patterns();
    test_len_zero();
    run_random(4, 1, 1'b1);
    test_mid_reset();
    test_back_to_back();
`ifdef MISR_HD_STATS_EN
    test_hd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
